// File: rtl/competition_controller.sv
// Game-control FSM for the quiz-buzzer competition view: answer window, countdown,
// scoring with saturation/floor, per-round history and winner detection.
module competition_controller #(
    parameter int TICKS_PER_MS   = 100000,
    parameter int ANSWER_TIME_MS = 30000,
    parameter int MAX_ROUNDS     = 9,
    parameter int POINTS_CORRECT = 2,
    parameter int POINTS_WRONG   = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [3:0]  player_btn,
    input  logic        start,
    input  logic        judge_correct,
    input  logic        judge_wrong,
    input  logic        browse,
    input  logic        clear,
    output logic [3:0]  play_count,
    output logic [2:0]  state,
    output logic [17:0] time_remain,
    output logic [6:0]  player1_score,
    output logic [6:0]  player2_score,
    output logic [6:0]  player3_score,
    output logic [6:0]  player4_score,
    output logic [17:0] player1_list,
    output logic [17:0] player2_list,
    output logic [17:0] player3_list,
    output logic [17:0] player4_list,
    output logic [2:0]  select_player,
    output logic [2:0]  winner
);

    localparam int               PRE_W       = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST    = PRE_W'(TICKS_PER_MS - 1);
    localparam logic [3:0]       ROUNDS_LAST = 4'(MAX_ROUNDS);
    localparam logic [17:0]      TIME_LOAD   = 18'(ANSWER_TIME_MS);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ANSWERING = 3'd1,
        ANSWERED  = 3'd2
    } state_t;

    state_t            cur_state;
    state_t            next_state;
    logic [PRE_W-1:0]  prescaler;
    logic [PRE_W-1:0]  prescaler_next;
    logic [3:0]        rounds_next;
    logic [17:0]       time_next;
    logic [2:0]        select_next;
    logic [2:0]        winner_next;
    logic [3:0][6:0]   score;
    logic [3:0][6:0]   score_next;
    logic [3:0][17:0]  list;
    logic [3:0][17:0]  list_next;
    int                adj;
    int                top_score;
    logic              top_tied;
    logic [2:0]        top_player;

    assign state         = cur_state;
    assign player1_score = score[0];
    assign player2_score = score[1];
    assign player3_score = score[2];
    assign player4_score = score[3];
    assign player1_list  = list[0];
    assign player2_list  = list[1];
    assign player3_list  = list[2];
    assign player4_list  = list[3];

    // Leader search over the registered scores, so winner lags the score update by one cycle.
    always_comb begin
        top_score  = -1;
        top_tied   = 1'b0;
        top_player = 3'd0;
        for (int p = 0; p < 4; p++) begin
            if (int'(score[p]) > top_score) begin
                top_score  = int'(score[p]);
                top_player = 3'(p + 1);
                top_tied   = 1'b0;
            end else if (int'(score[p]) == top_score) begin
                top_tied = 1'b1;
            end
        end
    end

    always_comb begin
        next_state     = cur_state;
        prescaler_next = prescaler;
        rounds_next    = play_count;
        time_next      = time_remain;
        select_next    = select_player;
        score_next     = score;
        list_next      = list;
        adj            = 0;
        winner_next    = (play_count == ROUNDS_LAST && !top_tied) ? top_player : 3'd0;

        if (clear) begin
            next_state     = IDLE;
            prescaler_next = '0;
            rounds_next    = '0;
            time_next      = '0;
            select_next    = '0;
            score_next     = '0;
            list_next      = '0;
            winner_next    = '0;
        end else begin
            case (cur_state)
                IDLE: begin
                    if (browse) begin
                        select_next = (select_player == 3'd4) ? 3'd0 : select_player + 3'd1;
                    end
                    if (start && play_count < ROUNDS_LAST) begin
                        next_state     = ANSWERING;
                        time_next      = TIME_LOAD;
                        prescaler_next = '0;
                        select_next    = 3'd0;
                    end
                end
                ANSWERING: begin
                    // A buzz takes priority over a timeout landing in the same cycle.
                    if (player_btn != 4'b0000) begin
                        next_state = ANSWERED;
                        if (player_btn[0])      select_next = 3'd1;
                        else if (player_btn[1]) select_next = 3'd2;
                        else if (player_btn[2]) select_next = 3'd3;
                        else                    select_next = 3'd4;
                    end else if (prescaler == PRE_LAST) begin
                        prescaler_next = '0;
                        time_next      = time_remain - 18'd1;
                        if (time_remain == 18'd1) begin
                            next_state  = ANSWERED;
                            select_next = 3'd0;
                        end
                    end else begin
                        prescaler_next = prescaler + PRE_W'(1);
                    end
                end
                ANSWERED: begin
                    if (judge_correct || judge_wrong) begin
                        next_state  = IDLE;
                        rounds_next = play_count + 4'd1;
                        select_next = 3'd0;
                        for (int p = 0; p < 4; p++) begin
                            if (select_player == 3'(p + 1)) begin
                                if (judge_correct) begin
                                    adj = int'(score[p]) + POINTS_CORRECT;
                                    if (adj > 99) adj = 99;
                                    list_next[p][2*play_count +: 2] = 2'b01;
                                end else begin
                                    adj = int'(score[p]) - POINTS_WRONG;
                                    if (adj < 0) adj = 0;
                                    list_next[p][2*play_count +: 2] = 2'b10;
                                end
                                score_next[p] = 7'(adj);
                            end
                        end
                    end
                end
                default: next_state = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_state     <= IDLE;
            prescaler     <= '0;
            play_count    <= '0;
            time_remain   <= '0;
            select_player <= '0;
            score         <= '0;
            list          <= '0;
            winner        <= '0;
        end else if (en) begin
            cur_state     <= next_state;
            prescaler     <= prescaler_next;
            play_count    <= rounds_next;
            time_remain   <= time_next;
            select_player <= select_next;
            score         <= score_next;
            list          <= list_next;
            winner        <= winner_next;
        end
    end

endmodule

// File: doc/competition_controller.md
Name: competition_controller

Overview:
Game-control FSM for the quiz-buzzer competition mode. Drives the signals the competition display view consumes: state, round counter, answer countdown, per-player scores, per-round result history, selected player and winner. Inputs are debounced single-cycle button pulses from the input layer. Active only while the competition view is selected.

Parameters:
TICKS_PER_MS, 100000, clk cycles per millisecond of countdown
ANSWER_TIME_MS, 30000, countdown load value in ms (must be ≤ 99999)
MAX_ROUNDS, 9, rounds per game (1..9)
POINTS_CORRECT, 2, score added on correct answer
POINTS_WRONG, 1, score subtracted on wrong answer

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
en  in  1  1 = competition view selected; 0 = freeze all state, timer and prescaler
player_btn  in  4  one-cycle buzz pulses, bit k = player k+1
start  in  1  host pulse: open answer window
judge_correct  in  1  host pulse: answer correct
judge_wrong  in  1  host pulse: answer wrong
browse  in  1  host pulse: cycle displayed player in idle
clear  in  1  host pulse: new game
play_count  out  4  rounds completed, 0..MAX_ROUNDS
state  out  3  0 IDLE, 1 ANSWERING, 2 ANSWERED
time_remain  out  18  ms left in answer window
player1_score..player4_score  out  7 each  scores, 0..99
player1_list..player4_list  out  18 each  round history, 2 bits per round
select_player  out  3  idle: browse index 0..4; ANSWERED: buzzing player 1..4, 0 = timeout
winner  out  3  0 = none/tie, 1..4 = winning player

Behaviour:
- Reset (async, rst=1) and clear (sync, when en=1): every output 0, prescaler 0, state IDLE. clear overrides all other inputs in the same cycle, from any state.
- en=0: all registers hold; pulses ignored.
- IDLE (0): browse → select_player 0→1→2→3→4→0. start with play_count < MAX_ROUNDS → ANSWERING next cycle; time_remain ← ANSWER_TIME_MS, prescaler ← 0, select_player ← 0. start with play_count = MAX_ROUNDS ignored. player_btn and judge pulses ignored.
- ANSWERING (1): prescaler counts 0..TICKS_PER_MS-1; at terminal count time_remain decrements by 1. When time_remain goes 1→0 → ANSWERED with select_player=0 (timeout). Any player_btn bit set → ANSWERED next cycle, select_player = lowest set index+1, time_remain frozen. Buzz in the same cycle as timeout: buzz wins. start/browse/judge ignored.
- ANSWERED (2): player_btn, start and browse ignored. judge_correct or judge_wrong (both set: correct wins) → IDLE next cycle, play_count+1, select_player ← 0.
  - select_player = p ≠ 0: correct → score_p + POINTS_CORRECT, saturating at 99; wrong → score_p − POINTS_WRONG, floor 0. Round code for p = 01 (correct) / 10 (wrong).
  - select_player = 0: no score change; all players' round codes 00.
  - Players not answering: code 00.
- Round history: round r (1-based = play_count+1 at judgement) occupies list bits [2r-1:2r-2]. Bits of future rounds stay 0.
- winner: registered 1 cycle after the scores/play_count update. While play_count = MAX_ROUNDS: index of strictly highest score, 0 if the top score is tied. Otherwise 0.
- All outputs registered; state change visible the cycle after the triggering pulse.

Test Plan:
- Reset then clear: TICKS_PER_MS=4, ANSWER_TIME_MS=3; assert rst mid-ANSWERING → all outputs 0 immediately; with play_count=3, pulse clear → all 0 next cycle.
- Timeout: start → state=1, time_remain=3; after 12 cycles time_remain=0, state=2, select_player=0; judge_wrong → state=0, play_count=1, scores unchanged, all lists 0.
- Simultaneous buzz: in ANSWERING, player_btn=4'b1010 → select_player=2, time_remain frozen; judge_correct → player2_score=2, player2_list[1:0]=01, play_count=1.
- Saturation/floor: preload player1 to 98, correct → 99; player3 at 0, wrong → 0 with code 10 recorded; both judges set at once → treated as correct.
- Game end: MAX_ROUNDS=2; two rounds won by player4 → play_count=2, winner=4 one cycle later; further start ignored (state stays 0). Tie at the top → winner=0.
- Freeze/browse: en=0 during ANSWERING for 20 cycles → time_remain unchanged. In IDLE, 5 browse pulses → select_player 1,2,3,4,0.
